axis_layer_scheduler: RTL

//  Sequences whole-network execution on the accelerator by issuing DMA read commands for weights and pixels per layer iteration.

---
 rtl/axis_sched_pkg.sv | 26 ++
 rtl/axis_layer_scheduler_if.sv | 49 ++++
 rtl/sched_desc_table.sv | 38 +++
 rtl/axis_layer_scheduler.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/axis_sched_pkg.sv
// Package for the layer scheduler.
// Holds the datapath widths, the FSM state encoding and the layer descriptor record.
package axis_sched_pkg;

   localparam int unsigned ADDR_WIDTH = 32;
   localparam int unsigned LEN_WIDTH  = 23;
   localparam int unsigned ITR_WIDTH  = 16;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StLoad  = 3'd1,
      StWCmd  = 3'd2,
      StXCmd  = 3'd3,
      StDrain = 3'd4,
      StDone  = 3'd5
   } state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] w_base;
      logic [LEN_WIDTH-1:0]  w_len;
      logic [ADDR_WIDTH-1:0] x_base;
      logic [LEN_WIDTH-1:0]  x_len;
      logic [ITR_WIDTH-1:0]  itr;
   } desc_t;

endpackage

// File: rtl/axis_layer_scheduler_if.sv
// Bus bundle between the layer scheduler and its surroundings.
// Carries: descriptor write port, run control (num_layers/start), weights and pixels DMA command
// channels, the retire strobe (out_last) and status (busy/done/cur_layer/err_retire).
// master: the scheduler side. slave: the environment side (CPU config, DMAs, accelerator).
interface axis_layer_scheduler_if #(
   parameter int unsigned MAX_LAYERS = 16
) ();
   localparam int unsigned LAYER_W = $clog2(MAX_LAYERS);

   logic                                 cfg_wr_en;
   logic [LAYER_W-1:0]                   cfg_wr_layer;
   logic [axis_sched_pkg::ADDR_WIDTH-1:0] cfg_w_base;
   logic [axis_sched_pkg::LEN_WIDTH-1:0]  cfg_w_len;
   logic [axis_sched_pkg::ADDR_WIDTH-1:0] cfg_x_base;
   logic [axis_sched_pkg::LEN_WIDTH-1:0]  cfg_x_len;
   logic [axis_sched_pkg::ITR_WIDTH-1:0]  cfg_itr;
   logic [LAYER_W:0]                     num_layers;
   logic                                 start;

   logic                                 w_cmd_valid;
   logic                                 w_cmd_ready;
   logic [axis_sched_pkg::ADDR_WIDTH-1:0] w_cmd_addr;
   logic [axis_sched_pkg::LEN_WIDTH-1:0]  w_cmd_len;
   logic                                 x_cmd_valid;
   logic                                 x_cmd_ready;
   logic [axis_sched_pkg::ADDR_WIDTH-1:0] x_cmd_addr;
   logic [axis_sched_pkg::LEN_WIDTH-1:0]  x_cmd_len;

   logic                                 out_last;
   logic                                 busy;
   logic                                 done;
   logic [LAYER_W-1:0]                   cur_layer;
   logic                                 err_retire;

   modport master (
      input  cfg_wr_en, cfg_wr_layer, cfg_w_base, cfg_w_len, cfg_x_base, cfg_x_len, cfg_itr,
      input  num_layers, start, w_cmd_ready, x_cmd_ready, out_last,
      output w_cmd_valid, w_cmd_addr, w_cmd_len, x_cmd_valid, x_cmd_addr, x_cmd_len,
      output busy, done, cur_layer, err_retire
   );

   modport slave (
      output cfg_wr_en, cfg_wr_layer, cfg_w_base, cfg_w_len, cfg_x_base, cfg_x_len, cfg_itr,
      output num_layers, start, w_cmd_ready, x_cmd_ready, out_last,
      input  w_cmd_valid, w_cmd_addr, w_cmd_len, x_cmd_valid, x_cmd_addr, x_cmd_len,
      input  busy, done, cur_layer, err_retire
   );

endinterface

// File: rtl/sched_desc_table.sv
// Layer descriptor register file.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_wr_en/i_wr_idx/i_wr_data synchronous
// write; i_rd_idx read index; o_rd_data registered read data (valid one cycle after i_rd_idx).
// The storage itself is not reset so descriptors survive a scheduler reset.
module sched_desc_table
   import axis_sched_pkg::*;
#(
   parameter int unsigned MAX_LAYERS = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_wr_en,
   input  logic [$clog2(MAX_LAYERS)-1:0] i_wr_idx,
   input  desc_t                         i_wr_data,
   input  logic [$clog2(MAX_LAYERS)-1:0] i_rd_idx,
   output desc_t                         o_rd_data
);

   desc_t r_mem [MAX_LAYERS];
   desc_t r_rd_data;

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_idx] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= r_mem[i_rd_idx];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axis_layer_scheduler.sv
// Whole-network layer scheduler.
// Walks the descriptor table layer by layer and, for every iteration, issues one weights DMA
// command followed by one pixels DMA command. Issued iterations are counted in flight until the
// accelerator's output tlast handshake (out_last) retires them.
// Ports: aclk, aresetn (async active-low); bus (master modport) carrying config, start,
// both DMA command channels, out_last and the busy/done/cur_layer/err_retire status.
module axis_layer_scheduler
   import axis_sched_pkg::*;
#(
   parameter int unsigned MAX_LAYERS   = 16,
   parameter int unsigned MAX_INFLIGHT = 2
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   axis_layer_scheduler_if.master bus
);

   localparam int unsigned LAYER_W = $clog2(MAX_LAYERS);
   localparam int unsigned INF_W   = $clog2(MAX_INFLIGHT + 1);
   localparam logic [INF_W-1:0] INF_MAX = INF_W'(MAX_INFLIGHT);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [LAYER_W:0]      r_layer;
   logic [LAYER_W:0]      w_layer_nxt;
   logic [LAYER_W:0]      w_layer_inc;
   logic [LAYER_W:0]      r_num_layers;
   logic [ITR_WIDTH-1:0]  r_itr;
   logic [ITR_WIDTH-1:0]  r_itr_cnt;
   logic [ITR_WIDTH:0]    w_itr_cnt_inc;
   logic [ADDR_WIDTH-1:0] r_w_addr;
   logic [LEN_WIDTH-1:0]  r_w_len;
   logic [ADDR_WIDTH-1:0] r_x_base;
   logic [LEN_WIDTH-1:0]  r_x_len;
   logic [INF_W-1:0]      r_inflight;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_err;

   desc_t                 w_desc;
   desc_t                 w_wr_desc;
   logic                  w_wr_en;
   logic                  w_start_acc;
   logic                  w_slot_free;
   logic                  w_w_valid;
   logic                  w_x_valid;
   logic                  w_w_hs;
   logic                  w_x_hs;
   logic                  w_itr_last;
   logic                  w_layers_last;

   // Descriptor table: read index is the next-cycle layer so LOAD sees its row one cycle later.
   assign w_wr_en   = bus.cfg_wr_en && !r_busy;
   assign w_wr_desc = '{w_base: bus.cfg_w_base, w_len: bus.cfg_w_len,
                        x_base: bus.cfg_x_base, x_len: bus.cfg_x_len, itr: bus.cfg_itr};

   sched_desc_table #(
      .MAX_LAYERS (MAX_LAYERS)
   ) u_desc_table (
      .i_clk     (aclk),
      .i_rst_n   (aresetn),
      .i_wr_en   (w_wr_en),
      .i_wr_idx  (bus.cfg_wr_layer),
      .i_wr_data (w_wr_desc),
      .i_rd_idx  (w_layer_nxt[LAYER_W-1:0]),
      .o_rd_data (w_desc)
   );

   assign w_start_acc   = (r_state == StIdle) && bus.start;
   assign w_slot_free   = r_inflight < INF_MAX;
   assign w_w_hs        = w_w_valid && bus.w_cmd_ready;
   assign w_x_hs        = w_x_valid && bus.x_cmd_ready;
   assign w_itr_cnt_inc = {1'b0, r_itr_cnt} + 1;
   assign w_itr_last    = w_itr_cnt_inc == {1'b0, r_itr};
   assign w_layer_inc   = r_layer + 1;
   assign w_layers_last = w_layer_inc == r_num_layers;

   // FSM state register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state and layer pointer
   always_comb begin
      w_state_nxt = r_state;
      w_layer_nxt = r_layer;
      unique case (r_state)
         StIdle: begin
            if (bus.start) begin
               w_layer_nxt = '0;
               w_state_nxt = (bus.num_layers == '0) ? StDone : StLoad;
            end
         end
         StLoad: begin
            if (w_desc.itr == '0) begin
               w_layer_nxt = w_layer_inc;
               w_state_nxt = w_layers_last ? StDrain : StLoad;
            end else begin
               w_state_nxt = StWCmd;
            end
         end
         StWCmd: begin
            if (w_w_hs) begin
               w_state_nxt = StXCmd;
            end
         end
         StXCmd: begin
            if (w_x_hs) begin
               if (w_itr_last) begin
                  w_layer_nxt = w_layer_inc;
                  w_state_nxt = w_layers_last ? StDrain : StLoad;
               end else begin
                  w_state_nxt = StWCmd;
               end
            end
         end
         StDrain: begin
            if (r_inflight == '0) begin
               w_state_nxt = StDone;
            end
         end
         StDone:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   // FSM outputs: the weight command is held back while the in-flight window is full
   always_comb begin
      w_w_valid = 1'b0;
      w_x_valid = 1'b0;
      unique case (r_state)
         StWCmd:  w_w_valid = w_slot_free;
         StXCmd:  w_x_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath: descriptor latch, address accumulator, counters and status
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_layer      <= '0;
         r_num_layers <= '0;
         r_itr        <= '0;
         r_itr_cnt    <= '0;
         r_w_addr     <= '0;
         r_w_len      <= '0;
         r_x_base     <= '0;
         r_x_len      <= '0;
         r_inflight   <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_layer <= w_layer_nxt;
         r_done  <= (r_state == StDone);

         if (w_start_acc) begin
            r_num_layers <= bus.num_layers;
            r_busy       <= 1'b1;
         end else if (r_state == StDone) begin
            r_busy <= 1'b0;
         end

         if ((r_state == StLoad) && (w_desc.itr != '0)) begin
            r_w_addr  <= w_desc.w_base;
            r_w_len   <= w_desc.w_len;
            r_x_base  <= w_desc.x_base;
            r_x_len   <= w_desc.x_len;
            r_itr     <= w_desc.itr;
            r_itr_cnt <= '0;
         end else if (w_x_hs) begin
            r_itr_cnt <= w_itr_cnt_inc[ITR_WIDTH-1:0];
            r_w_addr  <= r_w_addr + ADDR_WIDTH'(r_w_len);
         end

         // An issue and a retire in the same cycle cancel out.
         if (w_x_hs && !bus.out_last) begin
            r_inflight <= r_inflight + 1;
         end else if (!w_x_hs && bus.out_last && (r_inflight != '0)) begin
            r_inflight <= r_inflight - 1;
         end

         if (w_start_acc) begin
            r_err <= 1'b0;
         end
         if (bus.out_last && !w_x_hs && (r_inflight == '0)) begin
            r_err <= 1'b1;
         end
      end
   end

   assign bus.w_cmd_valid = w_w_valid;
   assign bus.w_cmd_addr  = r_w_addr;
   assign bus.w_cmd_len   = r_w_len;
   assign bus.x_cmd_valid = w_x_valid;
   assign bus.x_cmd_addr  = r_x_base;
   assign bus.x_cmd_len   = r_x_len;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.cur_layer   = r_layer[LAYER_W-1:0];
   assign bus.err_retire  = r_err;

endmodule
